// File: rtl/reg_file_param.sv
// reg_file_param: 2**ADDR_W x DATA_W register file with two combinational
// read ports, two write ports (A = ALU writeback, B = load writeback) and
// a per-register pending (scoreboard) bit. Register 0 is hardwired to zero.
// Register OUT_IDX is mirrored on cpu_out.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write
// data to the read ports and cpu_out. Port A wins over port B.
module reg_file_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int OUT_IDX = 2**ADDR_W-1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] WB_A,
  input  logic [DATA_W-1:0] WB_D,
  input  logic              wb_enable,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              busy1,
  output logic              busy2,
  output logic [DATA_W-1:0] cpu_out
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs, regs_nxt, view;
  logic [DEPTH-1:0]             pend, pend_nxt, busy_view;
  logic [DEPTH-1:0]             wa_hit, wb_hit, lk_hit;

  // Per-register decode of the write and lock ports. Index 0 never hits,
  // and nothing hits while reset is held, so reset also masks forwarding.
  always_comb begin
    wa_hit = '0;
    wb_hit = '0;
    lk_hit = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wa_hit[i] = RST_N && write_enable && (WA        == ADDR_W'(i));
      wb_hit[i] = RST_N && wb_enable    && (WB_A      == ADDR_W'(i));
      lk_hit[i] = RST_N && lock_en      && (lock_addr == ADDR_W'(i));
    end
  end

  // Next-state per register: port A overrides port B on a shared address;
  // a lock beats the clear from a write in the same cycle.
  always_comb begin
    regs_nxt = regs;
    pend_nxt = pend;
    for (int i = 0; i < DEPTH; i++) begin
      if (wa_hit[i])      regs_nxt[i] = WD;
      else if (wb_hit[i]) regs_nxt[i] = WB_D;
      pend_nxt[i] = lk_hit[i] | (pend[i] & ~(wa_hit[i] | wb_hit[i]));
    end
  end

  // Storage and pending bits; reset clears everything asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs <= '0;
      pend <= '0;
    end else begin
      regs <= regs_nxt;
      pend <= pend_nxt;
    end
  end

  // What the read ports see: forwarded next-state or stored contents.
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    view      = regs_nxt;
    busy_view = pend & ~((wa_hit | wb_hit) & ~lk_hit);
`else
    view      = regs;
    busy_view = pend;
`endif
  end

  // Zero-latency read ports; address 0 always reads zero / not busy.
  always_comb begin
    RD1     = (RA1 == '0) ? '0 : view[RA1];
    RD2     = (RA2 == '0) ? '0 : view[RA2];
    busy1   = (RA1 != '0) && busy_view[RA1];
    busy2   = (RA2 != '0) && busy_view[RA2];
    cpu_out = view[OUT_IDX];
  end
endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: directed scenarios followed by
// random traffic, checked against an array-based behavioural model.
// Honours REG_FILE_BYPASS_EN the same way the design does.
module tb_reg_file_param;
  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] RA1, RA2, WA, WB_A, lock_addr;
  logic [7:0] WD, WB_D;
  logic       write_enable, wb_enable, lock_en;
  logic [7:0] RD1, RD2, cpu_out;
  logic       busy1, busy2;

  // wide instance
  logic [4:0]  p_RA1, p_RA2, p_WA, p_WB_A, p_lock_addr;
  logic [15:0] p_WD, p_WB_D, p_RD1, p_RD2, p_cpu_out;
  logic        p_we, p_wbe, p_lock_en, p_busy1, p_busy2;

  int checks = 0;
  int passed = 0;

  int mem [16];
  bit pnd [16];

  always #5 CLK = ~CLK;

  reg_file_param u_dut (
    .CLK(CLK), .RST_N(RST_N), .RA1(RA1), .RA2(RA2),
    .WA(WA), .WD(WD), .write_enable(write_enable),
    .WB_A(WB_A), .WB_D(WB_D), .wb_enable(wb_enable),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .RD1(RD1), .RD2(RD2), .busy1(busy1), .busy2(busy2), .cpu_out(cpu_out)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(5), .OUT_IDX(31)) u_wide (
    .CLK(CLK), .RST_N(RST_N), .RA1(p_RA1), .RA2(p_RA2),
    .WA(p_WA), .WD(p_WD), .write_enable(p_we),
    .WB_A(p_WB_A), .WB_D(p_WB_D), .wb_enable(p_wbe),
    .lock_en(p_lock_en), .lock_addr(p_lock_addr),
    .RD1(p_RD1), .RD2(p_RD2), .busy1(p_busy1), .busy2(p_busy2), .cpu_out(p_cpu_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Value a read of address a should return right now (before the edge).
  function automatic int exp_rd(int a);
    if (a == 0 || !RST_N) return 0;
`ifdef REG_FILE_BYPASS_EN
    if (write_enable && int'(WA) == a) return int'(WD);
    if (wb_enable && int'(WB_A) == a) return int'(WB_D);
`endif
    return mem[a];
  endfunction

  function automatic bit exp_busy(int a);
    bit b;
    if (a == 0 || !RST_N) return 1'b0;
    b = pnd[a];
`ifdef REG_FILE_BYPASS_EN
    if (((write_enable && int'(WA) == a) || (wb_enable && int'(WB_A) == a)) &&
        !(lock_en && int'(lock_addr) == a)) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".RD1"},   32'(RD1),     32'(exp_rd(int'(RA1))));
    chk({tag, ".RD2"},   32'(RD2),     32'(exp_rd(int'(RA2))));
    chk({tag, ".busy1"}, 32'(busy1),   32'(exp_busy(int'(RA1))));
    chk({tag, ".busy2"}, 32'(busy2),   32'(exp_busy(int'(RA2))));
    chk({tag, ".cpu"},   32'(cpu_out), 32'(exp_rd(15)));
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_edge();
    if (!RST_N) return;
    if (write_enable && WA != 0) begin
      mem[WA] = int'(WD);
      pnd[WA] = 1'b0;
    end
    if (wb_enable && WB_A != 0) begin
      if (!(write_enable && WA == WB_A)) mem[WB_A] = int'(WB_D);
      pnd[WB_A] = 1'b0;
    end
    if (lock_en && lock_addr != 0) pnd[lock_addr] = 1'b1;
  endtask

  task automatic model_reset();
    foreach (mem[i]) begin
      mem[i] = 0;
      pnd[i] = 1'b0;
    end
  endtask

  // Entered just after a negedge with inputs set; returns after next negedge.
  task automatic cyc(input string tag);
    #1 check_outputs(tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle();
    write_enable = 1'b0;
    wb_enable    = 1'b0;
    lock_en      = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    RA1 = 0; RA2 = 0; WA = 0; WB_A = 0; lock_addr = 0;
    WD = 0; WB_D = 0;
    idle();
    p_RA1 = 0; p_RA2 = 0; p_WA = 0; p_WB_A = 0; p_lock_addr = 0;
    p_WD = 0; p_WB_D = 0; p_we = 0; p_wbe = 0; p_lock_en = 0;
    model_reset();

    // reset state
    #2;
    chk("rst.RD1", 32'(RD1), 0);
    chk("rst.cpu", 32'(cpu_out), 0);
    chk("rst.busy2", 32'(busy2), 0);
    @(negedge CLK);

    // writes and locks ignored while reset is held
    write_enable = 1; WA = 3; WD = 8'hA5; lock_en = 1; lock_addr = 3; RA1 = 3; RA2 = 3;
    cyc("in_rst");
    chk("in_rst.hold", 32'(RD1), 0);

    // release: the write in the first cycle is performed
    RST_N = 1'b1; lock_en = 0;
    cyc("release");
    idle();
    #1 chk("release.RD1", 32'(RD1), 32'h A5);
    cyc("post_release");

    // async reset pulse mid-cycle
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    chk("async.RD1", 32'(RD1), 0);
    chk("async.cpu", 32'(cpu_out), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc("after_async");

    // zero register is never written
    write_enable = 1; WA = 0; WD = 8'hFF; RA1 = 0; lock_en = 1; lock_addr = 0;
    cyc("zero_wr");
    idle();
    #1;
    chk("zero.RD1", 32'(RD1), 0);
    chk("zero.busy1", 32'(busy1), 0);

    // port conflict: A wins
    write_enable = 1; WA = 5; WD = 8'h11;
    wb_enable = 1; WB_A = 5; WB_D = 8'h22; RA1 = 5;
    cyc("conflict");
    idle();
    #1 chk("conflict.RD1", 32'(RD1), 32'h11);

    // scoreboard
    lock_en = 1; lock_addr = 7; RA2 = 7;
    cyc("lock7");
    idle();
    #1 chk("lock7.busy2", 32'(busy2), 1);
    wb_enable = 1; WB_A = 7; WB_D = 8'h3C;
    cyc("wb7");
    idle();
    #1;
    chk("wb7.busy2", 32'(busy2), 0);
    chk("wb7.RD2", 32'(RD2), 32'h3C);
    lock_en = 1; lock_addr = 7; write_enable = 1; WA = 7; WD = 8'h44;
    cyc("lockwr7");
    idle();
    #1;
    chk("lockwr7.busy2", 32'(busy2), 1);
    chk("lockwr7.RD2", 32'(RD2), 32'h44);

    // bypass behaviour on reg 15 (also cpu_out)
    write_enable = 1; WA = 15; WD = 8'h33;
    cyc("pre15");
    WD = 8'h5A; RA1 = 15;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("byp.RD1", 32'(RD1), 32'h5A);
    chk("byp.cpu", 32'(cpu_out), 32'h5A);
`else
    chk("byp.RD1", 32'(RD1), 32'h33);
    chk("byp.cpu", 32'(cpu_out), 32'h33);
`endif
    cyc("byp");
    idle();
    #1;
    chk("byp_next.RD1", 32'(RD1), 32'h5A);
    chk("byp_next.cpu", 32'(cpu_out), 32'h5A);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      write_enable = ($urandom_range(0, 1) == 1);
      wb_enable    = ($urandom_range(0, 2) == 0);
      lock_en      = ($urandom_range(0, 3) == 0);
      WA   = 4'($urandom_range(0, 15));
      WB_A = ($urandom_range(0, 3) == 0) ? WA : 4'($urandom_range(0, 15));
      lock_addr = ($urandom_range(0, 3) == 0) ? WA : 4'($urandom_range(0, 15));
      WD   = 8'($urandom);
      WB_D = 8'($urandom);
      RA1  = ($urandom_range(0, 2) == 0) ? WA : 4'($urandom_range(0, 15));
      RA2  = ($urandom_range(0, 2) == 0) ? WB_A : 4'($urandom_range(0, 15));
      cyc("rand");
    end
    idle();

    // wide configuration
    p_we = 1; p_WA = 31; p_WD = 16'hBEEF; p_RA1 = 31; p_RA2 = 31;
    @(posedge CLK);
    @(negedge CLK);
    p_we = 0;
    #1;
    chk("wide.RD1", 32'(p_RD1), 32'hBEEF);
    chk("wide.RD2", 32'(p_RD2), 32'hBEEF);
    chk("wide.cpu", 32'(p_cpu_out), 32'hBEEF);
    chk("wide.busy1", 32'(p_busy1), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 8: data width in bits; SHALL be 1 or more.
REQ-002 Parameter ADDR_W, default 4: address width; depth is 2**ADDR_W registers.
REQ-003 Parameter OUT_IDX, default 2**ADDR_W-1: index of the register mirrored on cpu_out; SHALL be 1 to 2**ADDR_W-1.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 RA1, RA2  input  ADDR_W each  read addresses, ports 1 and 2.
REQ-007 WA, WD, write_enable  input  ADDR_W/DATA_W/1  write port A (ALU writeback).
REQ-008 WB_A, WB_D, wb_enable  input  ADDR_W/DATA_W/1  write port B (load writeback).
REQ-009 lock_en, lock_addr  input  1/ADDR_W  marks the register as pending (result outstanding).
REQ-010 RD1, RD2  output  DATA_W each  read data, combinational from RA1/RA2.
REQ-011 busy1, busy2  output  1 each  pending bit of RA1/RA2.
REQ-012 cpu_out  output  DATA_W  contents of register OUT_IDX.

Function
REQ-013 Storage: 2**ADDR_W x DATA_W registers; register 0 reads as zero and is never written.
REQ-014 RDn SHALL be 0 when RAn = 0, else register[RAn]; read latency is zero cycles.
REQ-015 Port A SHALL write WD to register[WA] at the clock edge when write_enable = 1 and WA is not 0.
REQ-016 Port B SHALL write WB_D to register[WB_A] at the clock edge when wb_enable = 1 and WB_A is not 0.
REQ-017 When both ports write the same nonzero address in the same cycle, port A data SHALL be stored and port B data dropped.
REQ-018 Pending bit array: one bit per register; pending[0] is constant 0.
REQ-019 lock_en = 1 with nonzero lock_addr SHALL set pending[lock_addr] at the edge.
REQ-020 Any completed write (port A or B) SHALL clear the pending bit of its address at the edge.
REQ-021 A lock and a write to the same address in the same cycle: data stored, pending SHALL end set (lock wins).
REQ-022 busyn SHALL be pending[RAn], and 0 when RAn = 0.
REQ-023 cpu_out SHALL be register[OUT_IDX] with zero latency; writes to other addresses do not affect it.
REQ-024 Address arithmetic: no wrap-around or out-of-range case exists because depth = 2**ADDR_W exactly.

Reset
REQ-025 RST_N low SHALL immediately clear all registers and all pending bits, independent of CLK.
REQ-026 During reset: RD1 = RD2 = cpu_out = 0, busy1 = busy2 = 0; writes and locks are ignored.
REQ-027 Deassertion takes effect at the first rising CLK edge after RST_N goes high; a write presented in that cycle SHALL be performed.

Configuration
REQ-028 Macro REG_FILE_BYPASS_EN.
REQ-029 Defined: a read (RDn, cpu_out) of an address being written in the same cycle SHALL return the incoming write data, with port A over port B. busyn SHALL read 0 for an address being written without a simultaneous lock.
REQ-030 Undefined: reads return stored, pre-edge contents; there is no forwarding path.
REQ-031 Register 0 SHALL read 0 in both configurations.

Verification
REQ-032 Reset: write 0xA5 to reg 3, pulse RST_N low mid-cycle -> RD1(RA1=3) = 0 immediately and cpu_out = 0.
REQ-033 Zero register: write_enable = 1, WA = 0, WD = 0xFF -> RD1(RA1=0) = 0 next cycle and busy1 = 0.
REQ-034 Write conflict: WA = WB_A = 5, WD = 0x11, WB_D = 0x22 -> reg 5 reads 0x11 after the edge.
REQ-035 Scoreboard: lock reg 7 -> busy2(RA2=7) = 1. wb_enable with WB_A = 7, WB_D = 0x3C -> busy2 = 0 and RD2 = 0x3C. Lock and write reg 7 in the same cycle -> busy2 stays 1.
REQ-036 Bypass: write 0x5A to reg 15 with RA1 = 15 in the same cycle. With REG_FILE_BYPASS_EN, RD1 and cpu_out = 0x5A in that cycle; without it, both show the old value and 0x5A appears on the next cycle.
REQ-037 Parameters: DATA_W = 16, ADDR_W = 5, OUT_IDX = 31 -> write 0xBEEF to reg 31 and read it back on RD1, RD2 and cpu_out.
